// File: rtl/felis_mem_pkg.sv
// Shared types for the store buffer: memory-side FSM states and the buffered store entry.
package felis_mem_pkg;

  localparam int SB_WADDR_W = 30;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_GAP
  } sb_state_t;

  typedef struct packed {
    logic [SB_WADDR_W-1:0] addr;
    logic [31:0]           data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Core-side and memory-side bundles of the store buffer.
// The core is master of sb_core_if; the store buffer is master of sb_mem_if.
interface sb_core_if #(
  parameter int AW = 32
);
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic          st_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_ready;
  logic [31:0]   ld_data;
  logic          ld_done;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr,
    input  st_ready, ld_ready, ld_data, ld_done
  );
  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr,
    output st_ready, ld_ready, ld_data, ld_done
  );
endinterface

interface sb_mem_if;
  logic [31:0] mem_in_addr;
  logic [31:0] mem_in_data;
  logic        mem_in_valid;
  logic        mem_in_ready;
  logic [31:0] mem_out_addr;
  logic        mem_out_valid;
  logic [31:0] mem_out_data;
  logic        mem_out_ready;

  modport master (
    output mem_in_addr, mem_in_data, mem_in_valid, mem_out_addr, mem_out_valid,
    input  mem_in_ready, mem_out_data, mem_out_ready
  );
  modport slave (
    input  mem_in_addr, mem_in_data, mem_in_valid, mem_out_addr, mem_out_valid,
    output mem_in_ready, mem_out_data, mem_out_ready
  );
endinterface

// File: rtl/sb_fwd_match.sv
// Combinational store-to-load forwarding search: finds the youngest valid entry
// whose word address matches, scanning from head (oldest) towards head+count-1.
module sb_fwd_match
  import felis_mem_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH)
) (
  input  sb_entry_t             ent [DEPTH],
  input  logic [PW-1:0]         head,
  input  logic [PW:0]           count,
  input  logic [SB_WADDR_W-1:0] addr,
  output logic                  hit,
  output logic [31:0]           data
);

  // Later matches overwrite earlier ones, so the last hit is the youngest.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < count) && (ent[head + PW'(i)].addr == addr)) begin
        hit  = 1'b1;
        data = ent[head + PW'(i)].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order write-back store buffer in front of the BRAM memory: single-cycle store accept,
// load forwarding from pending stores, and a serialising read/write FSM toward memory.
module store_buffer
  import felis_mem_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic     clk,
  input  logic     reset,
  sb_core_if.slave core,
  sb_mem_if.master mem,
  output logic     empty
);

  localparam int          PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  sb_entry_t             ent_q [DEPTH];
  sb_entry_t             ent_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [PW:0]           count_q, count_d;
  sb_state_t             state_q, state_d;
  logic                  ld_pend_q, ld_pend_d;
  logic [SB_WADDR_W-1:0] ld_waddr_q, ld_waddr_d;
  logic [31:0]           ld_data_q, ld_data_d;
  logic                  ld_done_q, ld_done_d;
  logic [31:0]           in_addr_q, in_addr_d, in_data_q, in_data_d;
  logic                  in_valid_q, in_valid_d;
  logic [31:0]           out_addr_q, out_addr_d;
  logic                  out_valid_q, out_valid_d;

  logic                  st_acc, ld_acc, pop, fwd_hit;
  logic [31:0]           fwd_data;
  logic [SB_WADDR_W-1:0] st_word, ld_word;

  assign st_word = SB_WADDR_W'(core.st_addr[AW-1:2]);
  assign ld_word = SB_WADDR_W'(core.ld_addr[AW-1:2]);
  assign st_acc  = core.st_valid && core.st_ready;
  assign ld_acc  = core.ld_valid && core.ld_ready;

  assign core.st_ready      = (count_q != FULL);
  assign core.ld_ready      = !ld_pend_q;
  assign core.ld_data       = ld_data_q;
  assign core.ld_done       = ld_done_q;
  assign mem.mem_in_addr    = in_addr_q;
  assign mem.mem_in_data    = in_data_q;
  assign mem.mem_in_valid   = in_valid_q;
  assign mem.mem_out_addr   = out_addr_q;
  assign mem.mem_out_valid  = out_valid_q;
  assign empty              = (count_q == '0);

  // Search uses the pre-store count, so a same-cycle store is never forwarded.
  sb_fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_fwd (
    .ent   (ent_q),
    .head  (head_q),
    .count (count_q),
    .addr  (ld_word),
    .hit   (fwd_hit),
    .data  (fwd_data)
  );

  always_comb begin
    ent_d       = '{addr: st_word, data: core.st_data};
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    ld_pend_d   = ld_pend_q;
    ld_waddr_d  = ld_waddr_q;
    ld_data_d   = ld_data_q;
    ld_done_d   = 1'b0;
    in_addr_d   = in_addr_q;
    in_data_d   = in_data_q;
    in_valid_d  = in_valid_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;

    if (ld_acc) begin
      if (fwd_hit) begin
        ld_done_d = 1'b1;
        ld_data_d = fwd_data;
      end else begin
        ld_pend_d  = 1'b1;
        ld_waddr_d = ld_word;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (ld_pend_q) begin
          state_d     = S_RD;
          out_valid_d = 1'b1;
          out_addr_d  = {ld_waddr_q, 2'b00};
        end else if (count_q != '0) begin
          state_d    = S_WR;
          in_valid_d = 1'b1;
          in_addr_d  = {ent_q[head_q].addr, 2'b00};
          in_data_d  = ent_q[head_q].data;
        end
      end
      S_WR: begin
        if (mem.mem_in_ready) begin
          in_valid_d = 1'b0;
          pop        = 1'b1;
          head_d     = head_q + PW'(1);
          state_d    = S_GAP;
        end
      end
      S_RD: begin
        if (mem.mem_out_ready) begin
          out_valid_d = 1'b0;
          ld_data_d   = mem.mem_out_data;
          ld_done_d   = 1'b1;
          ld_pend_d   = 1'b0;
          state_d     = S_GAP;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (st_acc) tail_d = tail_q + PW'(1);
  end

  assign count_d = count_q + (PW+1)'(st_acc) - (PW+1)'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ld_pend_q   <= 1'b0;
      ld_waddr_q  <= '0;
      ld_data_q   <= '0;
      ld_done_q   <= 1'b0;
      in_addr_q   <= '0;
      in_data_q   <= '0;
      in_valid_q  <= 1'b0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ld_pend_q   <= ld_pend_d;
      ld_waddr_q  <= ld_waddr_d;
      ld_data_q   <= ld_data_d;
      ld_done_q   <= ld_done_d;
      in_addr_q   <= in_addr_d;
      in_data_q   <= in_data_d;
      in_valid_q  <= in_valid_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (st_acc) ent_q[tail_q] <= ent_d;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus a random phase, checked against a
// queue-of-pending-stores reference and a responsive memory model.
module tb_store_buffer;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  logic empty;

  always #5 clk = ~clk;

  sb_core_if #(.AW(32)) core_if ();
  sb_mem_if             mem_if ();

  store_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .core  (core_if),
    .mem   (mem_if),
    .empty (empty)
  );

  typedef struct {
    bit [31:0] a;
    bit [31:0] d;
  } st_t;

  st_t       ref_q[$];
  st_t       wr_log[$];
  bit [31:0] ref_mem [bit [31:0]];
  bit [31:0] mem_arr [bit [31:0]];
  int        checks = 0;
  int        failures = 0;
  bit        miss_out;
  bit [31:0] miss_val;
  bit        out_seen;
  bit        mem_hold;
  int        wr_wait, rd_wait;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] ref_rd(bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic bit [31:0] mem_rd(bit [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : 32'h0;
  endfunction

  // One clock: account for what the edge consumes, advance, then check and drive memory.
  task automatic tick();
    bit        r, st_acc, ld_acc, wr_pop, rd_done, exp_done, hit, gap_chk;
    bit [31:0] exp_val, la;
    r = reset; exp_done = 0; exp_val = 0; gap_chk = 0;
    if (!r) begin
      chk1("st_ready", core_if.st_ready, ref_q.size() < DEPTH);
      chk1("ld_ready", core_if.ld_ready, !miss_out);
      st_acc  = core_if.st_valid && core_if.st_ready;
      ld_acc  = core_if.ld_valid && core_if.ld_ready;
      wr_pop  = mem_if.mem_in_valid && mem_if.mem_in_ready;
      rd_done = mem_if.mem_out_valid && mem_if.mem_out_ready;
      if (rd_done) begin
        exp_done = 1; exp_val = miss_val; miss_out = 0; gap_chk = 1;
      end
      if (ld_acc) begin
        la = core_if.ld_addr & ~32'h3;
        hit = 0;
        foreach (ref_q[i]) if (ref_q[i].a == la) begin hit = 1; exp_val = ref_q[i].d; end
        if (hit) exp_done = 1;
        else begin miss_out = 1; miss_val = ref_rd(la); end
      end
      if (wr_pop) begin
        gap_chk = 1;
        wr_log.push_back('{mem_if.mem_in_addr, mem_if.mem_in_data});
        mem_arr[mem_if.mem_in_addr] = mem_if.mem_in_data;
        chk1("wr_pending", ref_q.size() != 0, 1'b1);
        if (ref_q.size() != 0) begin
          chk("wr_addr", mem_if.mem_in_addr, ref_q[0].a);
          chk("wr_data", mem_if.mem_in_data, ref_q[0].d);
          ref_mem[ref_q[0].a] = ref_q[0].d;
          void'(ref_q.pop_front());
        end
      end
      if (st_acc) ref_q.push_back('{core_if.st_addr & ~32'h3, core_if.st_data});
    end else begin
      ref_q.delete();
      miss_out = 0;
    end
    @(posedge clk); #1;
    chk1("ld_done", core_if.ld_done, exp_done);
    if (exp_done) chk("ld_data", core_if.ld_data, exp_val);
    chk1("mem_excl", mem_if.mem_in_valid && mem_if.mem_out_valid, 1'b0);
    if (gap_chk) begin
      chk1("gap_in_valid", mem_if.mem_in_valid, 1'b0);
      chk1("gap_out_valid", mem_if.mem_out_valid, 1'b0);
    end
    chk1("empty", empty, ref_q.size() == 0);
    if (mem_if.mem_out_valid) out_seen = 1;
    mem_if.mem_in_ready  = 1'b0;
    mem_if.mem_out_ready = 1'b0;
    mem_if.mem_out_data  = 32'h0;
    if (reset) begin
      wr_wait = 0; rd_wait = 0;
    end else if (!mem_hold) begin
      if (mem_if.mem_in_valid) begin
        if (wr_wait == 0) begin mem_if.mem_in_ready = 1'b1; wr_wait = $urandom_range(0, 2); end
        else wr_wait--;
      end
      if (mem_if.mem_out_valid) begin
        if (rd_wait == 0) begin
          mem_if.mem_out_ready = 1'b1;
          mem_if.mem_out_data  = mem_rd(mem_if.mem_out_addr);
          rd_wait = $urandom_range(0, 2);
        end else rd_wait--;
      end
    end
  endtask

  task automatic settle(string tag, int budget);
    int n = 0;
    while ((ref_q.size() != 0 || miss_out) && n < budget) begin tick(); n++; end
    chk1({tag, "_settle_timeout"}, n < budget, 1'b1);
    repeat (4) tick();
  endtask

  task automatic wait_done(string tag, int budget, output logic [31:0] d);
    int n = 0;
    while (core_if.ld_done !== 1'b1 && n < budget) begin tick(); n++; end
    chk1({tag, "_done_timeout"}, core_if.ld_done, 1'b1);
    d = core_if.ld_data;
  endtask

  task automatic drive_st(bit [31:0] a, bit [31:0] d);
    core_if.st_valid = 1'b1; core_if.st_addr = a; core_if.st_data = d;
  endtask

  task automatic drive_ld(bit [31:0] a);
    core_if.ld_valid = 1'b1; core_if.ld_addr = a;
  endtask

  task automatic idle_inputs();
    core_if.st_valid = 1'b0; core_if.ld_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          n;
    reset = 1'b1;
    core_if.st_valid = 0; core_if.st_addr = 0; core_if.st_data = 0;
    core_if.ld_valid = 0; core_if.ld_addr = 0;
    mem_if.mem_in_ready = 0; mem_if.mem_out_ready = 0; mem_if.mem_out_data = 0;
    miss_out = 0; out_seen = 0; mem_hold = 0; wr_wait = 0; rd_wait = 0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk1("rst_st_ready", core_if.st_ready, 1'b1);
    chk1("rst_ld_ready", core_if.ld_ready, 1'b1);
    chk1("rst_ld_done", core_if.ld_done, 1'b0);
    chk("rst_ld_data", core_if.ld_data, 32'h0);
    chk1("rst_in_valid", mem_if.mem_in_valid, 1'b0);
    chk1("rst_out_valid", mem_if.mem_out_valid, 1'b0);
    chk("rst_in_addr", mem_if.mem_in_addr, 32'h0);
    chk("rst_in_data", mem_if.mem_in_data, 32'h0);
    chk("rst_out_addr", mem_if.mem_out_addr, 32'h0);
    chk1("rst_empty", empty, 1'b1);

    // Store then forwarded load, then drain
    out_seen = 0; wr_log.delete();
    drive_st(32'h100, 32'hA); tick();
    idle_inputs(); drive_ld(32'h100); tick();
    idle_inputs();
    chk1("fwd_done", core_if.ld_done, 1'b1);
    chk("fwd_data", core_if.ld_data, 32'hA);
    settle("fwd", 40);
    chk1("fwd_no_read", out_seen, 1'b0);
    chk("fwd_wr_count", wr_log.size(), 1);
    if (wr_log.size() >= 1) begin
      chk("fwd_wr_addr", wr_log[0].a, 32'h100);
      chk("fwd_wr_data", wr_log[0].d, 32'hA);
    end

    // Fill behind a stalled miss
    mem_hold = 1;
    drive_ld(32'h500); tick(); idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin drive_st(32'h600 + 32'(i) * 4, 32'(i) + 32'h10); tick(); end
    drive_st(32'h700, 32'hDEAD);
    chk1("full_st_ready", core_if.st_ready, 1'b0);
    tick(); idle_inputs();
    mem_hold = 0;
    n = 0;
    while (core_if.st_ready !== 1'b1 && n < 40) begin tick(); n++; end
    chk1("after_pop_st_ready", core_if.st_ready, 1'b1);
    chk("after_pop_count", ref_q.size(), DEPTH - 1);
    settle("fill", 100);

    // Youngest of duplicate stores is forwarded; drain order preserved
    wr_log.delete();
    drive_st(32'h200, 32'h1); tick();
    drive_st(32'h200, 32'h2); tick();
    idle_inputs(); drive_ld(32'h200); tick(); idle_inputs();
    chk1("dup_done", core_if.ld_done, 1'b1);
    chk("dup_data", core_if.ld_data, 32'h2);
    settle("dup", 40);
    chk("dup_wr_count", wr_log.size(), 2);
    if (wr_log.size() >= 2) begin
      chk("dup_wr_first", wr_log[0].d, 32'h1);
      chk("dup_wr_second", wr_log[1].d, 32'h2);
    end

    // Miss to memory on an empty buffer
    ref_mem[32'h300] = 32'h55; mem_arr[32'h300] = 32'h55;
    out_seen = 0;
    drive_ld(32'h300); tick(); idle_inputs();
    wait_done("miss", 20, d);
    chk("miss_data", d, 32'h55);
    chk1("miss_read_seen", out_seen, 1'b1);
    settle("miss", 20);

    // Same-cycle store and load: load sees the old memory value
    ref_mem[32'h400] = 32'h33; mem_arr[32'h400] = 32'h33;
    drive_st(32'h400, 32'h7); drive_ld(32'h400); tick(); idle_inputs();
    wait_done("same", 30, d);
    chk("same_cycle_data", d, 32'h33);
    settle("same", 40);
    chk("same_final_mem", mem_rd(32'h400), 32'h7);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      core_if.st_valid = 1'($urandom_range(0, 1));
      core_if.st_addr  = 32'h100 + 32'($urandom_range(0, 5)) * 4 + 32'($urandom_range(0, 3));
      core_if.st_data  = $urandom;
      core_if.ld_valid = ($urandom_range(0, 2) == 0);
      core_if.ld_addr  = 32'h100 + 32'($urandom_range(0, 5)) * 4 + 32'($urandom_range(0, 3));
      tick();
    end
    idle_inputs();
    settle("random", 300);

    // Reset while writing with a stalled miss outstanding
    mem_hold = 1;
    for (int i = 0; i < 3; i++) begin drive_st(32'h800 + 32'(i) * 4, 32'(i) + 32'h80); tick(); end
    idle_inputs();
    n = 0;
    while (mem_if.mem_in_valid !== 1'b1 && n < 10) begin tick(); n++; end
    chk1("rst_mid_in_wr", mem_if.mem_in_valid, 1'b1);
    drive_ld(32'h900); tick(); idle_inputs();
    reset = 1'b1; wr_log.delete();
    tick();
    reset = 1'b0;
    chk1("rst_mid_empty", empty, 1'b1);
    chk1("rst_mid_in_valid", mem_if.mem_in_valid, 1'b0);
    chk1("rst_mid_out_valid", mem_if.mem_out_valid, 1'b0);
    chk1("rst_mid_ld_done", core_if.ld_done, 1'b0);
    mem_hold = 0;
    repeat (10) tick();
    chk("rst_mid_no_writes", wr_log.size(), 0);
    chk1("rst_mid_ld_ready", core_if.ld_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
